// File: rtl/sap_ctrl_pkg.sv
// Shared types and opcode constants for the SAP-II jump controller.
package sap_ctrl_pkg;

  localparam logic [7:0] OP_JMP = 8'hC3;
  localparam logic [7:0] OP_JM  = 8'hFA;
  localparam logic [7:0] OP_JZ  = 8'hCA;
  localparam logic [7:0] OP_JNZ = 8'hC2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_LO,
    FETCH_HI,
    EVAL,
    BAD
  } jc_state_t;

  typedef enum logic [1:0] {
    ALWAYS,
    SIGN,
    ZERO,
    NZERO
  } cond_t;

  typedef struct packed {
    logic s;
    logic z;
  } flags_t;

  typedef struct packed {
    logic  valid;
    cond_t cond;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [7:0] op);
    op_dec_t d;
    d.valid = 1'b1;
    d.cond  = ALWAYS;
    case (op)
      OP_JMP:  d.cond = ALWAYS;
      OP_JM:   d.cond = SIGN;
      OP_JZ:   d.cond = ZERO;
      OP_JNZ:  d.cond = NZERO;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic cond_met(input cond_t c, input flags_t f);
    case (c)
      ALWAYS:  return 1'b1;
      SIGN:    return f.s;
      ZERO:    return f.z;
      default: return ~f.z;
    endcase
  endfunction

endpackage

// File: rtl/sap_flag_reg.sv
// Sign/zero flag register, written from the ALU result bus on flag_we.
module sap_flag_reg (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       flag_we,
  input  logic [7:0] alu_res,
  output logic       s_f,
  output logic       z_f
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s_f <= 1'b0;
      z_f <= 1'b0;
    end else if (flag_we) begin
      s_f <= alu_res[7];
      z_f <= (alu_res == 8'h00);
    end
  end

endmodule

// File: rtl/jump_ctrl.sv
// Conditional-jump sequencer: fetches two operand bytes, evaluates the
// condition against the flag snapshot taken at accept, and loads the PC.
module jump_ctrl
  import sap_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              flag_we,
  input  logic [7:0]        alu_res,
  input  logic              op_valid,
  input  logic [7:0]        op_code,
  output logic              op_ready,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              done,
  output logic              bad_op,
  output logic              s_f,
  output logic              z_f
);

  jc_state_t state;
  cond_t     cond_r;
  flags_t    snap;
  flags_t    flags;
  op_dec_t   dec;
  logic [7:0] lo_r;

  sap_flag_reg u_flags (
    .clk     (clk),
    .clr_n   (clr_n),
    .flag_we (flag_we),
    .alu_res (alu_res),
    .s_f     (s_f),
    .z_f     (z_f)
  );

  assign flags = '{s: s_f, z: z_f};
  assign dec   = decode_op(op_code);

  // Outputs are registered alongside the state transition, so each one
  // already holds the value belonging to the state being entered.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      cond_r   <= ALWAYS;
      snap     <= '0;
      lo_r     <= '0;
      pc_addr  <= '0;
      op_ready <= 1'b1;
      mem_req  <= 1'b0;
      done     <= 1'b0;
      bad_op   <= 1'b0;
      pc_load  <= 1'b0;
    end else begin
      done    <= 1'b0;
      bad_op  <= 1'b0;
      pc_load <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            op_ready <= 1'b0;
            if (dec.valid) begin
              cond_r  <= dec.cond;
              snap    <= flags;
              mem_req <= 1'b1;
              state   <= FETCH_LO;
            end else begin
              bad_op <= 1'b1;
              done   <= 1'b1;
              state  <= BAD;
            end
          end
        end
        FETCH_LO: begin
          if (mem_ack) begin
            lo_r  <= mem_data;
            state <= FETCH_HI;
          end
        end
        FETCH_HI: begin
          if (mem_ack) begin
            pc_addr <= {mem_data, lo_r};
            mem_req <= 1'b0;
            done    <= 1'b1;
            pc_load <= cond_met(cond_r, snap);
            state   <= EVAL;
          end
        end
        EVAL, BAD: begin
          op_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          op_ready <= 1'b1;
          mem_req  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// Self-checking bench for jump_ctrl: directed vector table, reset abort,
// and randomized jumps checked against a flag/opcode reference model.
module tb_jump_ctrl;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        flag_we;
  logic [7:0]  alu_res;
  logic        op_valid;
  logic [7:0]  op_code;
  logic        op_ready;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic        pc_load;
  logic [15:0] pc_addr;
  logic        done;
  logic        bad_op;
  logic        s_f;
  logic        z_f;

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_s = 1'b0;
  bit          m_z = 1'b0;
  logic [15:0] last_addr = 16'h0000;

  jump_ctrl #(.ADDR_W(16)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .flag_we  (flag_we),
    .alu_res  (alu_res),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_ready (op_ready),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .pc_load  (pc_load),
    .pc_addr  (pc_addr),
    .done     (done),
    .bad_op   (bad_op),
    .s_f      (s_f),
    .z_f      (z_f)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; the flag model follows any write sampled on the edge.
  task automatic tick();
    bit         w;
    logic [7:0] v;
    w = flag_we;
    v = alu_res;
    @(posedge clk);
    if (w && clr_n) begin
      m_s = v[7];
      m_z = (v == 8'h00);
    end
    #1;
  endtask

  function automatic bit is_jump(input logic [7:0] op);
    return (op == 8'hC3) || (op == 8'hFA) || (op == 8'hCA) || (op == 8'hC2);
  endfunction

  function automatic bit model_taken(input logic [7:0] op);
    case (op)
      8'hC3:   return 1'b1;
      8'hFA:   return m_s;
      8'hCA:   return m_z;
      8'hC2:   return !m_z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_flags(input logic [7:0] v);
    flag_we = 1'b1;
    alu_res = v;
    tick();
    flag_we = 1'b0;
    check($sformatf("flags(%0h)/s_f", v), s_f, m_s);
    check($sformatf("flags(%0h)/z_f", v), z_f, m_z);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "/op_ready"}, op_ready, 1);
    check({tag, "/mem_req"}, mem_req, 0);
    check({tag, "/done"}, done, 0);
    check({tag, "/bad_op"}, bad_op, 0);
    check({tag, "/pc_load"}, pc_load, 0);
    check({tag, "/pc_addr"}, pc_addr, last_addr);
  endtask

  // One instruction from accept to the cycle op_ready returns; fw_k > 0
  // pulses flag_we in cycle N+fw_k.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [7:0] lo,
                        input logic [7:0] hi, input int w_lo, input int w_hi, input int fw_k,
                        input logic [7:0] fw_val, input bit exp_bad, input bit exp_taken,
                        input logic [15:0] exp_addr, input int exp_lat, input bit noise);
    int ack_lo;
    int ack_hi;
    check({tag, "/accept_ready"}, op_ready, 1);
    op_valid = 1'b1;
    op_code  = op;
    tick();
    if (exp_bad) begin
      op_valid = noise;
      op_code  = 8'($urandom);
      mem_ack  = noise;
      check({tag, "/bad_op"}, bad_op, 1);
      check({tag, "/bad_done"}, done, 1);
      check({tag, "/bad_req"}, mem_req, 0);
      check({tag, "/bad_load"}, pc_load, 0);
      check({tag, "/bad_ready"}, op_ready, 0);
      check({tag, "/bad_addr"}, pc_addr, last_addr);
      tick();
      op_valid = 1'b0;
      mem_ack  = 1'b0;
      check_idle({tag, "/after"});
      return;
    end
    ack_lo = 1 + w_lo;
    ack_hi = 2 + w_lo + w_hi;
    for (int k = 1; k <= exp_lat; k++) begin
      op_valid = noise;
      op_code  = 8'($urandom);
      flag_we  = (k == fw_k);
      alu_res  = (k == fw_k) ? fw_val : 8'($urandom);
      mem_ack  = (k == ack_lo) || (k == ack_hi) || (noise && k == exp_lat);
      mem_data = (k == ack_lo) ? lo : (k == ack_hi) ? hi : 8'($urandom);
      check($sformatf("%s/k%0d/mem_req", tag, k), mem_req, (k <= ack_hi));
      check($sformatf("%s/k%0d/done", tag, k), done, (k == exp_lat));
      check($sformatf("%s/k%0d/pc_load", tag, k), pc_load, (k == exp_lat) && exp_taken);
      check($sformatf("%s/k%0d/op_ready", tag, k), op_ready, 0);
      check($sformatf("%s/k%0d/s_f", tag, k), s_f, m_s);
      check($sformatf("%s/k%0d/z_f", tag, k), z_f, m_z);
      check($sformatf("%s/k%0d/pc_addr", tag, k), pc_addr,
            (k == exp_lat) ? exp_addr : last_addr);
      tick();
    end
    op_valid = 1'b0;
    flag_we  = 1'b0;
    mem_ack  = 1'b0;
    last_addr = exp_addr;
    check_idle({tag, "/after"});
  endtask

  typedef struct {
    bit          set;
    logic [7:0]  alu;
    logic [7:0]  op;
    logic [7:0]  lo;
    logic [7:0]  hi;
    int          w_lo;
    int          w_hi;
    int          fw_k;
    logic [7:0]  fw_val;
    bit          exp_bad;
    bit          exp_taken;
    logic [15:0] exp_addr;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1, 8'h80, 8'hFA, 8'h34, 8'h12, 0, 0, 0, 8'h00, 0, 1, 16'h1234, 3};
    vecs[1] = '{1, 8'h00, 8'hC2, 8'h00, 8'h20, 0, 0, 0, 8'h00, 0, 0, 16'h2000, 3};
    vecs[2] = '{0, 8'h00, 8'hCA, 8'h00, 8'h20, 0, 0, 0, 8'h00, 0, 1, 16'h2000, 3};
    vecs[3] = '{1, 8'h01, 8'hCA, 8'h78, 8'h56, 3, 3, 1, 8'h00, 0, 0, 16'h5678, 9};
    vecs[4] = '{0, 8'h00, 8'h76, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 0, 16'h5678, 1};
    vecs[5] = '{0, 8'h00, 8'hC3, 8'hAB, 8'hCD, 1, 0, 0, 8'h00, 0, 1, 16'hCDAB, 4};
    vecs[6] = '{1, 8'h7F, 8'hFA, 8'h01, 8'h02, 0, 0, 0, 8'h00, 0, 0, 16'h0201, 3};
    vecs[7] = '{1, 8'hFF, 8'hC2, 8'hEF, 8'hBE, 0, 2, 0, 8'h00, 0, 1, 16'hBEEF, 5};
    vecs[8] = '{0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 0, 16'hBEEF, 1};
    vecs[9] = '{1, 8'h00, 8'hC3, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 1, 16'h0000, 3};

    clr_n    = 1'b0;
    flag_we  = 1'b0;
    alu_res  = 8'h00;
    op_valid = 1'b0;
    op_code  = 8'h00;
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    #12;
    check_idle("reset");
    check("reset/s_f", s_f, 0);
    check("reset/z_f", z_f, 0);
    clr_n = 1'b1;
    tick();
    check_idle("idle");

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].set) set_flags(vecs[i].alu);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].lo, vecs[i].hi, vecs[i].w_lo,
             vecs[i].w_hi, vecs[i].fw_k, vecs[i].fw_val, vecs[i].exp_bad,
             vecs[i].exp_taken, vecs[i].exp_addr, vecs[i].exp_lat, 1'b0);
    end

    // Reset while waiting in FETCH_HI aborts the jump.
    set_flags(8'h80);
    op_valid = 1'b1;
    op_code  = 8'hC3;
    tick();
    op_valid = 1'b0;
    mem_ack  = 1'b1;
    mem_data = 8'h11;
    tick();
    mem_ack = 1'b0;
    check("abort/req_hi", mem_req, 1);
    tick();
    clr_n = 1'b0;
    #1;
    m_s = 1'b0;
    m_z = 1'b0;
    last_addr = 16'h0000;
    check_idle("abort/now");
    check("abort/s_f", s_f, 0);
    check("abort/z_f", z_f, 0);
    tick();
    check_idle("abort/held");
    clr_n = 1'b1;
    tick();
    check_idle("abort/release");
    run_op("post_rst", 8'hC3, 8'h99, 8'h88, 0, 0, 0, 8'h00, 0, 1, 16'h8899, 3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] op;
      logic [7:0] lo;
      logic [7:0] hi;
      int         w_lo;
      int         w_hi;
      int         lat;
      int         fw_k;
      int         pick;
      if ($urandom_range(0, 1) == 1)
        set_flags(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      pick = $urandom_range(0, 4);
      case (pick)
        0:       op = 8'hC3;
        1:       op = 8'hFA;
        2:       op = 8'hCA;
        3:       op = 8'hC2;
        default: op = 8'($urandom);
      endcase
      lo   = 8'($urandom);
      hi   = 8'($urandom);
      w_lo = $urandom_range(0, 3);
      w_hi = $urandom_range(0, 3);
      lat  = 3 + w_lo + w_hi;
      fw_k = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lat) : 0;
      if (is_jump(op))
        run_op($sformatf("rnd%0d", i), op, lo, hi, w_lo, w_hi, fw_k,
               ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom),
               1'b0, model_taken(op), {hi, lo}, lat, 1'b1);
      else
        run_op($sformatf("rnd%0d", i), op, lo, hi, 0, 0, 0, 8'h00,
               1'b1, 1'b0, last_addr, 1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jump_ctrl.md
# jump_ctrl

Conditional-jump sequencer for the SAP-II datapath. It owns the sign/zero flag register and runs JMP/JM/JZ/JNZ. For each jump it fetches the two operand bytes through a req/ack handshake, then evaluates the condition against a flag snapshot and drives the program-counter load. It sits between the instruction decoder, the ALU result bus and the memory/PC path.

## Interface
Parameters:
- `ADDR_W`, default 16: program-counter width; must equal 2 x 8.

Ports:
- `clk`  in  1  system clock; everything is sampled on its rising edge.
- `clr_n`  in  1  reset, asynchronous, active-low.
- `flag_we`  in  1  flag write strobe from the decoder.
- `alu_res`  in  8  ALU result bus.
- `op_valid`  in  1  decoder presents an opcode.
- `op_code`  in  8  opcode byte.
- `op_ready`  out  1  controller can accept an opcode.
- `mem_req`  out  1  operand byte request.
- `mem_ack`  in  1  operand byte present on `mem_data`.
- `mem_data`  in  8  operand byte.
- `pc_load`  out  1  load the PC with `pc_addr`.
- `pc_addr`  out  16  jump target, {hi, lo}.
- `done`  out  1  instruction complete, one-cycle pulse.
- `bad_op`  out  1  unsupported opcode, one-cycle pulse.
- `s_f`  out  1  sign flag.
- `z_f`  out  1  zero flag.

## Operation
Flag register:
- On `flag_we`: `s_f` <= `alu_res[7]`, `z_f` <= (`alu_res` == 0).
- The write works in every FSM state.
- It holds its value otherwise.

Supported opcodes and conditions:
- C3 JMP: always taken.
- FA JM: taken if S = 1.
- CA JZ: taken if Z = 1.
- C2 JNZ: taken if Z = 0.

FSM states: IDLE, FETCH_LO, FETCH_HI, EVAL, BAD.
- IDLE: `op_ready` = 1.
  - On `op_valid` with a supported opcode: latch the condition and the flag snapshot {S, Z}, then go to FETCH_LO.
  - On `op_valid` with any other opcode: go to BAD.
- BAD: `bad_op` = 1 and `done` = 1 for one cycle, then IDLE.
- FETCH_LO: `mem_req` = 1; stay until `mem_ack`. On the ack edge, capture `mem_data` into lo and go to FETCH_HI.
- FETCH_HI: same behaviour, capturing hi, then go to EVAL.
- EVAL, one cycle, then IDLE:
  - `done` = 1.
  - `pc_load` = 1 if taken.
  - `pc_addr` = {hi, lo}.

Outputs and boundary rules:
- All outputs are Moore: decoded from the state or registered.
- The condition uses the snapshot taken at the accept edge. The snapshot is the register value before any `flag_we` on that same edge.
- A `flag_we` during the fetch states updates `s_f`/`z_f` but never changes the branch outcome.
- `mem_ack` outside the FETCH states is ignored.
- `op_valid` outside IDLE is ignored; the decoder holds it until `op_ready`.
- `pc_addr` holds its last target between jumps.

## Timing
- Reset values of outputs:
  - `s_f` = 0, `z_f` = 0, `pc_addr` = 0.
  - `mem_req`, `pc_load`, `done`, `bad_op` = 0.
  - `op_ready` = 1; state = IDLE.
- Reset mid-instruction aborts immediately: no `pc_load`, no `done`, and captured bytes are discarded.
- Flags are visible one cycle after the `flag_we` edge.
- Minimum jump latency (acks immediate): accept edge N, FETCH_LO in cycle N+1, FETCH_HI in cycle N+2, EVAL with `done`/`pc_load` high in cycle N+3, `op_ready` again in cycle N+4.
- Each wait cycle without `mem_ack` adds one cycle; there is no timeout.
- Bad-opcode latency: `bad_op`/`done` high in cycle N+1.
- Back-to-back instructions: minimum spacing is 4 cycles for a jump and 2 cycles for a bad opcode.

## Structure
- Package `sap_ctrl_pkg`:
  - opcode constants `OP_JMP`, `OP_JM`, `OP_JZ`, `OP_JNZ`;
  - state enum `jc_state_t`;
  - condition enum `cond_t` (ALWAYS, SIGN, ZERO, NZERO).
- Sub-module `sap_flag_reg`: the S/Z register with `clr_n` and `flag_we`, instantiated once.
- The FSM, operand capture and condition evaluation live in `jump_ctrl`.

## Test plan
- Reset then idle: every output at its reset value; `op_ready` = 1; no `mem_req`.
- `flag_we` with `alu_res` = 80 -> S = 1, Z = 0. Then JM (FA) with bytes 34, 12 and immediate acks -> `pc_load` = 1, `pc_addr` = 1234, `done` in cycle N+3.
- `flag_we` with `alu_res` = 00, then JNZ (C2) with bytes 00, 20 -> `done` = 1, `pc_load` = 0. Then JZ (CA) with the same bytes -> `pc_load` = 1, `pc_addr` = 2000.
- JZ accepted while Z = 0, then `flag_we` with `alu_res` = 00 during FETCH_LO, with 3 wait cycles before each ack:
  - `z_f` rises;
  - jump not taken;
  - `done` in cycle N+9.
- Opcode 76 -> `bad_op` and `done` pulse in cycle N+1, no `mem_req`. JMP C3 afterwards works normally.
- `clr_n` low while in FETCH_HI -> immediate IDLE with all outputs at reset values; no `pc_load`; the next JMP fetches fresh bytes.
